// File: rtl/issue_ctrl.sv
// Issue controller: gates decoded instructions into ALU/LSU/CSR units with load-use scoreboarding.
// Latency: issue strobes are combinational with acceptance (0 cycles); state and scoreboard are registered.
// Backpressure: in_ready drops on RAW hazard, LSU full/not ready, CSR/FENCE/trap drain, CSR_WAIT and TRAP.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready + in_* fields  decoded instruction handshake (unit, load flag, fence/trap flags, regs)
//   alu_issue                        ALU op issued (single-cycle unit, never stalls)
//   lsu_issue/lsu_ready/lsu_done     LSU issue, LSU accept, one LSU op retired
//   lsu_wb_valid/lsu_wb_rd           load writeback, clears scoreboard entry
//   csr_issue/csr_done               CSR issue and completion
//   trap_valid/trap_cause/trap_ack   trap request (0 illegal, 1 ecall, 2 ebreak) and handler accept
//   busy                             not in RUN, or LSU ops still outstanding
module issue_ctrl #(
  parameter int NREG    = 32,
  parameter int LSU_MAX = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_unit,
  input  logic       in_is_load,
  input  logic       in_fence,
  input  logic       in_ecall,
  input  logic       in_ebreak,
  input  logic       in_illegal,
  input  logic [4:0] in_rd,
  input  logic [4:0] in_rs1,
  input  logic [4:0] in_rs2,
  input  logic       in_use_rs1,
  input  logic       in_use_rs2,
  output logic       alu_issue,
  output logic       lsu_issue,
  input  logic       lsu_ready,
  input  logic       lsu_done,
  input  logic       lsu_wb_valid,
  input  logic [4:0] lsu_wb_rd,
  output logic       csr_issue,
  input  logic       csr_done,
  output logic       trap_valid,
  output logic [1:0] trap_cause,
  input  logic       trap_ack,
  output logic       busy
);

  localparam int CW = $clog2(LSU_MAX + 1);
  localparam logic [CW-1:0] LSU_MAX_C = CW'(LSU_MAX);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_LSU = 2'd1;
  localparam logic [1:0] UNIT_CSR = 2'd2;
  localparam logic [1:0] UNIT_BAD = 2'd3;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_ECALL   = 2'd1;
  localparam logic [1:0] CAUSE_EBREAK  = 2'd2;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_CSR_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_TRAP     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [NREG-1:0] sb_q, sb_d;
  logic [1:0]      trap_cause_q, trap_cause_d;

  logic       hazard;
  logic       drained;
  logic       lsu_room;
  logic       is_trap;
  logic [1:0] cause_sel;
  logic       rdy_int;
  logic       alu_int;
  logic       lsu_int;
  logic       csr_int;

  // Entry 0 is never set, so reading sb_q for x0 always yields 0.
  assign hazard   = (in_use_rs1 & sb_q[in_rs1]) | (in_use_rs2 & sb_q[in_rs2]);
  assign drained  = (outstanding_q == '0);
  assign lsu_room = (outstanding_q < LSU_MAX_C);

  // Unit encoding 3 has no execution resource behind it, so it traps as illegal.
  assign is_trap  = in_illegal | in_ecall | in_ebreak | (in_unit == UNIT_BAD);

  always_comb begin
    cause_sel = CAUSE_EBREAK;
    if (in_illegal || (in_unit == UNIT_BAD)) begin
      cause_sel = CAUSE_ILLEGAL;
    end else if (in_ecall) begin
      cause_sel = CAUSE_ECALL;
    end
  end

  // Next-state and issue decode.
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    rdy_int      = 1'b0;
    alu_int      = 1'b0;
    lsu_int      = 1'b0;
    csr_int      = 1'b0;

    case (state_q)
      S_RUN: begin
        if (in_valid) begin
          if (is_trap) begin
            // Traps wait for the LSU to go quiet so the handler sees a precise state.
            rdy_int = drained;
            if (drained) begin
              state_d      = S_TRAP;
              trap_cause_d = cause_sel;
            end
          end else if (in_fence) begin
            rdy_int = drained;
          end else begin
            case (in_unit)
              UNIT_CSR: begin
                rdy_int = drained & ~hazard;
                csr_int = rdy_int;
                if (rdy_int) begin
                  state_d = S_CSR_WAIT;
                end
              end
              UNIT_LSU: begin
                rdy_int = ~hazard & lsu_ready & lsu_room;
                lsu_int = rdy_int;
              end
              default: begin
                rdy_int = ~hazard;
                alu_int = rdy_int;
              end
            endcase
          end
        end
      end
      S_CSR_WAIT: begin
        if (csr_done) begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          state_d = S_RUN;
        end
      end
      S_TRAP: begin
        if (trap_ack) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // In-flight LSU count: issue and retire in the same cycle cancel out;
  // a stray retire at zero is dropped rather than wrapping.
  always_comb begin
    outstanding_d = outstanding_q;
    if (lsu_int && !lsu_done) begin
      outstanding_d = outstanding_q + ONE_C;
    end else if (!lsu_int && lsu_done && !drained) begin
      outstanding_d = outstanding_q - ONE_C;
    end
  end

  // Scoreboard: clear applied first so a same-cycle set on the same register wins.
  always_comb begin
    sb_d = sb_q;
    if (lsu_wb_valid && (lsu_wb_rd != 5'd0)) begin
      sb_d[lsu_wb_rd] = 1'b0;
    end
    if (lsu_int && in_is_load && (in_rd != 5'd0)) begin
      sb_d[in_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      outstanding_q <= '0;
      sb_q          <= '0;
      trap_cause_q  <= CAUSE_ILLEGAL;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      sb_q          <= sb_d;
      trap_cause_q  <= trap_cause_d;
    end
  end

  // Handshake and issue strobes are forced low while reset is held,
  // since they are combinational from live inputs.
  assign in_ready   = rdy_int & rst_n;
  assign alu_issue  = alu_int & rst_n;
  assign lsu_issue  = lsu_int & rst_n;
  assign csr_issue  = csr_int & rst_n;

  assign trap_valid = (state_q == S_TRAP);
  assign trap_cause = trap_cause_q;
  assign busy       = (state_q != S_RUN) | ~drained;

endmodule
